// File: rtl/vram_pkg.sv
// Shared types and constants for the video RAM scheduler.
package vram_pkg;

    localparam int unsigned FB_BYTES = 21888;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned DATA_W   = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        StIdle,
        StWSetup,
        StWStrobe,
        StRead
    } state_e;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } wr_entry_t;

endpackage

// File: rtl/vram_sched_if.sv
// Timing, CPU write-port and SRAM bus signals of the video RAM scheduler.
interface vram_sched_if;
    import vram_pkg::*;

    logic       lineStart;
    logic       frameStart;
    logic       fetchEn;
    logic       cpuWrReq;
    addr_t      cpuWrAddr;
    data_t      cpuWrData;
    logic       cpuWrFull;
    logic [2:0] seq;
    addr_t      vramAddr;
    data_t      vramWrData;
    logic       vramDrive;
    logic       nVramOE;
    logic       nVramWE;

    modport slave (
        input  lineStart, frameStart, fetchEn, cpuWrReq, cpuWrAddr, cpuWrData,
        output cpuWrFull, seq, vramAddr, vramWrData, vramDrive, nVramOE, nVramWE
    );

    modport master (
        output lineStart, frameStart, fetchEn, cpuWrReq, cpuWrAddr, cpuWrData,
        input  cpuWrFull, seq, vramAddr, vramWrData, vramDrive, nVramOE, nVramWE
    );

endinterface

// File: rtl/wr_fifo.sv
// CPU write buffer: power-of-two FIFO with registered occupancy; pushes while full are dropped.
module wr_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 23,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vram_sched.sv
// Arbitrates the framebuffer SRAM between display fetches (seq 6-7) and buffered CPU writes.
module vram_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FB_BYTES   = vram_pkg::FB_BYTES
) (
    input  logic         clk,
    input  logic         nReset,
    vram_sched_if.slave  bus
);
    import vram_pkg::*;

    localparam int unsigned EntryW = $bits(wr_entry_t);
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]        seq_q, seq_d;
    state_e            state_q, state_d;
    logic              rd_last_q, rd_last_d;
    addr_t             fetch_q, fetch_d;
    addr_t             rd_addr_q, rd_addr_d;
    logic [EntryW-1:0] head_bits;
    wr_entry_t         head;
    logic              fifo_full, fifo_empty, pop;
    logic [CntW-1:0]   fifo_count;
    logic              free, rd_exit, have_wr, wr_slot, writing;

    wr_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EntryW)
    ) u_wr_fifo (
        .clk    (clk),
        .nReset (nReset),
        .push   (bus.cpuWrReq),
        .wdata  ({bus.cpuWrAddr, bus.cpuWrData}),
        .pop    (pop),
        .rdata  (head_bits),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign head  = wr_entry_t'(head_bits);
    assign seq_d = bus.lineStart ? 3'd0 : seq_q + 3'd1;
    // WSETUP lands on even seq only, and never on seq 6 while fetching, so WSTROBE never meets READ.
    assign wr_slot = !seq_d[0] && (!bus.fetchEn || seq_d != 3'd6);

    always_comb begin
        state_d   = state_q;
        rd_last_d = 1'b0;
        rd_addr_d = rd_addr_q;
        pop       = 1'b0;
        free      = 1'b0;
        rd_exit   = 1'b0;
        unique case (state_q)
            StRead: begin
                if (!rd_last_q) begin
                    rd_last_d = 1'b1;
                end else begin
                    free    = 1'b1;
                    rd_exit = 1'b1;
                end
            end
            StWSetup:  state_d = StWStrobe;
            StWStrobe: begin
                free = 1'b1;
                pop  = 1'b1;
            end
            default:   free = 1'b1;
        endcase
        // Look past the entry being popped so writes chain at one per two clocks.
        have_wr = pop ? (fifo_count > CntW'(1)) : !fifo_empty;
        if (free) begin
            if (bus.fetchEn && seq_d == 3'd6) begin
                state_d   = StRead;
                rd_addr_d = fetch_q;
            end else if (have_wr && wr_slot) begin
                state_d = StWSetup;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        fetch_d = fetch_q;
        if (bus.frameStart) begin
            fetch_d = rd_exit ? addr_t'(1) : '0;
        end else if (rd_exit) begin
            fetch_d = (fetch_q == addr_t'(FB_BYTES - 1)) ? '0 : fetch_q + addr_t'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            seq_q     <= '0;
            state_q   <= StIdle;
            rd_last_q <= 1'b0;
            fetch_q   <= '0;
            rd_addr_q <= '0;
        end else begin
            seq_q     <= seq_d;
            state_q   <= state_d;
            rd_last_q <= rd_last_d;
            fetch_q   <= fetch_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Strobes decode straight from the async-reset state so reset releases the bus at once.
    assign writing        = (state_q == StWSetup) || (state_q == StWStrobe);
    assign bus.seq        = seq_q;
    assign bus.cpuWrFull  = fifo_full;
    assign bus.vramDrive  = writing;
    assign bus.nVramOE    = (state_q != StRead);
    assign bus.nVramWE    = (state_q != StWStrobe);
    assign bus.vramAddr   = writing ? head.addr : rd_addr_q;
    assign bus.vramWrData = writing ? head.data : '0;

endmodule

// File: tb/tb_vram_sched.sv
// Directed bench for vram_sched: fetch slots, write timing, buffer full, address wrap, async reset.
module tb_vram_sched;

    localparam int unsigned TbFb = 16;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    vram_sched_if bus ();

    vram_sched #(
        .FIFO_DEPTH (4),
        .FB_BYTES   (TbFb)
    ) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic fe);
        nReset         = 1'b0;
        bus.lineStart  = 1'b0;
        bus.frameStart = 1'b0;
        bus.fetchEn    = fe;
        bus.cpuWrReq   = 1'b0;
        bus.cpuWrAddr  = '0;
        bus.cpuWrData  = '0;
        repeat (2) tick();
        check("rst_seq", 32'(bus.seq), 0);
        check("rst_addr", 32'(bus.vramAddr), 0);
        check("rst_wdata", 32'(bus.vramWrData), 0);
        check("rst_drive", 32'(bus.vramDrive), 0);
        check("rst_oe", 32'(bus.nVramOE), 1);
        check("rst_we", 32'(bus.nVramWE), 1);
        check("rst_full", 32'(bus.cpuWrFull), 0);
        nReset = 1'b1;
    endtask

    task automatic next_read(output logic [14:0] a);
        bit found;
        found = 1'b0;
        a = '0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (bus.nVramOE == 1'b0 && bus.seq == 3'd6) begin
                found = 1'b1;
                a = bus.vramAddr;
            end
        end
        if (!found) check("read_timeout", 0, 1);
    endtask

    task automatic wait_seq(input logic [2:0] s);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 9 && !found; i++) begin
            tick();
            if (bus.seq == s) found = 1'b1;
        end
        if (!found) check("seq_timeout", 0, 1);
    endtask

    initial begin
        logic [14:0] ra;
        logic [14:0] e_addr [5];
        logic [7:0]  e_data [5];
        logic [14:0] got_a [$];
        logic [7:0]  got_d [$];
        bit          found;
        int          we_low, drv;

        e_addr = '{15'h1234, 15'h0042, 15'h7fff, 15'h0003, 15'h0555};
        e_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Fetch slots after reset release
        do_reset(1'b1);
        for (int k = 1; k <= 24; k++) begin
            tick();
            check("seq_count", 32'(bus.seq), 32'(k % 8));
            check("oe_slot", 32'(bus.nVramOE), (k % 8 >= 6) ? 0 : 1);
            check("we_idle", 32'(bus.nVramWE), 1);
            if (k % 8 >= 6) check("read_addr", 32'(bus.vramAddr), 32'(k / 8));
        end

        // lineStart inside READ keeps the access and realigns the next one
        wait_seq(3'd6);
        check("read3_oe", 32'(bus.nVramOE), 0);
        check("read3_addr", 32'(bus.vramAddr), 3);
        bus.lineStart = 1'b1;
        tick();
        bus.lineStart = 1'b0;
        check("ls_seq0", 32'(bus.seq), 0);
        check("ls_read_kept", 32'(bus.nVramOE), 0);
        tick();
        check("ls_seq1", 32'(bus.seq), 1);
        check("ls_read_done", 32'(bus.nVramOE), 1);
        repeat (4) tick();
        check("ls_seq5_no_read", 32'(bus.nVramOE), 1);
        tick();
        check("ls_seq6", 32'(bus.seq), 6);
        check("ls_read4_oe", 32'(bus.nVramOE), 0);
        check("ls_read4_addr", 32'(bus.vramAddr), 4);

        // Single write with fetchEn low
        do_reset(1'b0);
        repeat (2) tick();
        bus.cpuWrReq  = 1'b1;
        bus.cpuWrAddr = 15'h0100;
        bus.cpuWrData = 8'h5a;
        tick();
        bus.cpuWrReq = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (bus.vramDrive) found = 1'b1;
        end
        check("wsetup_seen", 32'(found), 1);
        check("wsetup_we", 32'(bus.nVramWE), 1);
        check("wsetup_addr", 32'(bus.vramAddr), 32'h0100);
        check("wsetup_data", 32'(bus.vramWrData), 32'h5a);
        we_low = 0;
        drv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) check("wstrobe_follows", 32'(bus.nVramWE), 0);
            if (!bus.nVramWE) begin
                we_low++;
                check("wstrobe_addr", 32'(bus.vramAddr), 32'h0100);
                check("wstrobe_data", 32'(bus.vramWrData), 32'h5a);
                check("wstrobe_oe", 32'(bus.nVramOE), 1);
            end
            if (bus.vramDrive) drv++;
        end
        check("we_low_cycles", 32'(we_low), 1);
        check("drive_after_setup", 32'(drv), 1);
        check("single_full", 32'(bus.cpuWrFull), 0);

        // Five pushes into a 4-deep buffer while fetching
        do_reset(1'b1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (!bus.nVramWE) begin
                got_a.push_back(bus.vramAddr);
                got_d.push_back(bus.vramWrData);
            end
            if (bus.vramDrive && bus.nVramWE)
                check("wsetup_slot", 32'(bus.seq == 0 || bus.seq == 2 || bus.seq == 4), 1);
            if (bus.seq >= 3'd6) check("no_write_in_read", 32'(bus.vramDrive), 0);
            check("oe_we_exclusive", 32'(!bus.nVramOE && !bus.nVramWE), 0);
            if (k == 7) check("full_after_3", 32'(bus.cpuWrFull), 0);
            if (k == 8) check("full_after_4", 32'(bus.cpuWrFull), 1);
            bus.cpuWrReq = (k >= 4 && k <= 8);
            if (k >= 4 && k <= 8) begin
                bus.cpuWrAddr = e_addr[k-4];
                bus.cpuWrData = e_data[k-4];
            end
        end
        check("write_count", 32'(got_a.size()), 4);
        for (int i = 0; i < 4 && i < got_a.size(); i++) begin
            check("fifo_order_addr", 32'(got_a[i]), 32'(e_addr[i]));
            check("fifo_order_data", 32'(got_d[i]), 32'(e_data[i]));
        end

        // Fetch address wrap and frameStart
        do_reset(1'b1);
        for (int i = 0; i < TbFb + 2; i++) begin
            next_read(ra);
            if (i == 0) check("read_first", 32'(ra), 0);
            if (i == TbFb - 1) check("read_last", 32'(ra), TbFb - 1);
            if (i == TbFb) check("read_wrap", 32'(ra), 0);
            if (i == TbFb + 1) check("read_after_wrap", 32'(ra), 1);
        end
        wait_seq(3'd2);
        bus.frameStart = 1'b1;
        tick();
        bus.frameStart = 1'b0;
        next_read(ra);
        check("frame_mid_line", 32'(ra), 0);
        next_read(ra);
        check("frame_next1", 32'(ra), 1);
        next_read(ra);
        check("frame_next2", 32'(ra), 2);
        tick();
        check("frame_read2_oe", 32'(bus.nVramOE), 0);
        bus.frameStart = 1'b1;
        tick();
        bus.frameStart = 1'b0;
        next_read(ra);
        check("frame_with_exit", 32'(ra), 1);

        // Asynchronous reset during WSTROBE
        do_reset(1'b0);
        tick();
        bus.cpuWrReq  = 1'b1;
        bus.cpuWrAddr = 15'h2aaa;
        bus.cpuWrData = 8'hc3;
        tick();
        bus.cpuWrReq = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (!bus.nVramWE) found = 1'b1;
        end
        check("rst_wstrobe_seen", 32'(found), 1);
        #1 nReset = 1'b0;
        #1;
        check("async_we", 32'(bus.nVramWE), 1);
        check("async_drive", 32'(bus.vramDrive), 0);
        check("async_oe", 32'(bus.nVramOE), 1);
        tick();
        check("async_seq_held", 32'(bus.seq), 0);
        nReset = 1'b1;
        tick();
        check("post_rst_seq", 32'(bus.seq), 1);
        drv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.vramDrive) drv++;
        end
        check("entry_discarded", 32'(drv), 0);
        check("post_rst_full", 32'(bus.cpuWrFull), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/vram_sched.md
VRAM_SCHED -- requirements
Module: vram_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: CPU write buffer entries; power of two, minimum 2.
REQ-002 Parameter FB_BYTES, default 21888: framebuffer size in bytes (512x342 at 1 bpp).
REQ-003 clk  in  1  pixel clock; all state is updated on the rising edge.
REQ-004 nReset  in  1  asynchronous, active-low reset.
REQ-005 lineStart  in  1  one-clock pulse from the timing generator marking the first fetch slot of a line.
REQ-006 frameStart  in  1  one-clock pulse at the start of a frame.
REQ-007 fetchEn  in  1  high while display fetches are required; rises 8 clocks ahead of the shifter's vidActive.
REQ-008 cpuWrReq  in  1  CPU framebuffer write strobe; a byte is accepted when cpuWrReq=1 and cpuWrFull=0.
REQ-009 cpuWrAddr  in  15  framebuffer byte address of the CPU write.
REQ-010 cpuWrData  in  8  CPU write data.
REQ-011 cpuWrFull  out  1  write buffer full; pushes are ignored while it is high.
REQ-012 seq  out  3  pixel sequence count fed to the video shifter.
REQ-013 vramAddr  out  15  SRAM address.
REQ-014 vramWrData  out  8  SRAM write data.
REQ-015 vramDrive  out  1  high while vramWrData must be driven onto the SRAM data bus.
REQ-016 nVramOE  out  1  SRAM output enable, active low.
REQ-017 nVramWE  out  1  SRAM write enable, active low.

Function
REQ-018 seq shall increment by 1 modulo 8 on every clock; a lineStart pulse shall force seq to 0 on the following edge.
REQ-019 The FSM shall have four states: IDLE, WSETUP, WSTROBE and READ.
REQ-020 When fetchEn=1 and seq=5, the FSM shall enter READ for the cycles in which seq=6 and seq=7, then return to IDLE.
REQ-021 In READ: nVramOE=0, nVramWE=1, vramDrive=0, vramAddr=fetch address; the data stays stable through the negedge of the seq=7 cycle.
REQ-022 The fetch address shall increment by 1 on exit from READ; FB_BYTES-1 shall wrap to 0.
REQ-023 frameStart shall clear the fetch address to 0; if a fetch exits on the same edge, the counter becomes 1.
REQ-024 A write shall start only from IDLE, with the buffer non-empty, and either fetchEn=0 or seq in {0,2,4}, so that the write never overlaps the READ slot.
REQ-025 A write shall occupy two cycles:
- WSETUP: address and data driven, vramDrive=1, nVramWE=1.
- WSTROBE: nVramWE=0, address and data unchanged.
- The buffer entry shall pop on exit from WSTROBE.
REQ-026 Outside READ, nVramOE=1; outside WSTROBE, nVramWE=1; nVramOE and nVramWE shall never be low together.
REQ-027 The write buffer shall be FIFO-ordered; a push and a pop on the same edge shall leave the occupancy unchanged.
REQ-028 cpuWrFull shall be derived from registered occupancy only; a push while full shall be dropped without corrupting state.
REQ-029 With fetchEn=0, back-to-back writes shall sustain one write per 2 clocks.
REQ-030 A fetchEn fall during READ shall complete the READ; a fetchEn rise during a write shall let the write finish, and the write never spans seq=6.
REQ-031 A lineStart pulse during READ or a write shall not truncate the access; the next READ shall follow the new seq.

Reset
REQ-032 While nReset=0, the block shall hold:
- seq=0, vramAddr=0, vramWrData=0
- vramDrive=0, nVramOE=1, nVramWE=1, cpuWrFull=0
- FSM in IDLE, fetch address 0, buffer empty
REQ-033 Reset asserted mid-write shall deassert nVramWE and vramDrive immediately, without waiting for a clock; the in-flight entry shall be discarded.

Structure
REQ-034 Package vram_pkg shall hold the FSM state enum, FB_BYTES and the 15-bit address typedef.
REQ-035 The write buffer shall be a sub-module named wr_fifo, parameterised by depth and entry width (23 bits: address + data).

Verification
REQ-036 Reset release with fetchEn=1 and no writes -> reads at addresses 0,1,2 with nVramOE=0 exactly during seq 6-7; nVramWE stays 1.
REQ-037 Push A=0x0100/D=0x5A with fetchEn=0 -> WSETUP then WSTROBE at 0x0100/0x5A; nVramWE low for exactly 1 clock; buffer empty afterwards.
REQ-038 Five pushes with DEPTH=4 while fetchEn=1 -> cpuWrFull=1 after the 4th; the 5th is dropped; the 4 writes land in order at seq 0/2/4, never during seq 6-7.
REQ-039 Fetch address at 21887 -> next read uses 21887, the following read uses 0; a frameStart mid-line -> next read uses 0.
REQ-040 nReset=0 asserted during WSTROBE -> nVramWE=1 and vramDrive=0 with no clock edge; after release, seq=0 and the buffer is empty.
